// File: rtl/spi_shift_engine.sv
// SPI bit-level shift engine: drives the SCLK generator handshake, shifts
// tx words out on MOSI and assembles MISO bits into a right-aligned rx word.
module spi_shift_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  sclk_i,
    input  logic                  pos_edge_i,
    input  logic                  neg_edge_i,
    input  logic                  miso_i,
    output logic                  busy_o,
    output logic                  st_o,
    output logic                  last_o,
    output logic                  mosi_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  done_o
);

    localparam logic [CNT_WIDTH-1:0] FULL_LEN = CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic                    cpol_q;
    logic                    cpha_q;
    logic                    lsb_q;
    logic [CNT_WIDTH-1:0]    len_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [DATA_WIDTH-1:0]   tx_sr_q;
    logic [DATA_WIDTH-1:0]   rx_sr_q;

    logic                    busy_d;
    logic                    st_d;
    logic                    last_d;
    logic                    mosi_d;
    logic                    done_d;
    logic [DATA_WIDTH-1:0]   rx_data_d;

    logic                    lead_c;
    logic                    trail_c;
    logic                    in_xfer_c;
    logic                    more_c;
    logic                    sample_c;
    logic                    shift_c;
    logic                    present_only_c;
    logic                    finish_c;
    logic                    accept_c;
    logic [CNT_WIDTH-1:0]    eff_len_c;
    logic [DATA_WIDTH-1:0]   tx_load_c;
    logic [DATA_WIDTH-1:0]   tx_next_c;
    logic [DATA_WIDTH-1:0]   rx_align_c;

    function automatic logic head_bit(input logic lsb, input logic [DATA_WIDTH-1:0] sr);
        return lsb ? sr[0] : sr[DATA_WIDTH-1];
    endfunction

    // Edge decode; a trail pulse coinciding with lead is dropped in favour of lead.
    always_comb begin
        lead_c         = cpol_q ? neg_edge_i : pos_edge_i;
        trail_c        = (cpol_q ? pos_edge_i : neg_edge_i) & ~lead_c;
        in_xfer_c      = (state_q == XFER);
        more_c         = (cnt_q < len_q);
        sample_c       = in_xfer_c & more_c & (cpha_q ? trail_c : lead_c);
        shift_c        = in_xfer_c & more_c & (cpha_q ? lead_c : trail_c);
        present_only_c = cpha_q & (cnt_q == '0);
        finish_c       = in_xfer_c & last_o & (sclk_i == cpol_q);
        accept_c       = (state_q == IDLE) & start_i;
    end

    // Launch-time word preparation: clamp length, left-justify for MSB-first.
    always_comb begin
        eff_len_c  = ((len_i == '0) || (len_i > FULL_LEN)) ? FULL_LEN : len_i;
        tx_load_c  = lsb_i ? tx_data_i : (tx_data_i << (FULL_LEN - eff_len_c));
        tx_next_c  = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        rx_align_c = lsb_q ? (rx_sr_q >> (FULL_LEN - len_q)) : rx_sr_q;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = START;
            START:   state_d = XFER;
            XFER:    if (finish_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        busy_d    = (state_d == XFER);
        st_d      = (state_d == START);
        last_d    = last_o;
        mosi_d    = mosi_o;
        done_d    = 1'b0;
        rx_data_d = rx_data_o;
        case (state_q)
            IDLE: begin
                last_d = 1'b0;
                if (start_i && !cpha_i) begin
                    mosi_d = head_bit(lsb_i, tx_load_c);
                end
            end
            XFER: begin
                if (sample_c && (CNT_WIDTH'(cnt_q + CNT_WIDTH'(1)) == len_q)) begin
                    last_d = 1'b1;
                end
                if (shift_c) begin
                    mosi_d = head_bit(lsb_q, present_only_c ? tx_sr_q : tx_next_c);
                end
                if (finish_c) begin
                    last_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_align_c;
                end
            end
            default: begin
                last_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o    <= 1'b0;
            st_o      <= 1'b0;
            last_o    <= 1'b0;
            mosi_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
        end else begin
            busy_o    <= busy_d;
            st_o      <= st_d;
            last_o    <= last_d;
            mosi_o    <= mosi_d;
            done_o    <= done_d;
            rx_data_o <= rx_data_d;
        end
    end

    // Transfer datapath: captured mode, shift registers and bit counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            len_q   <= FULL_LEN;
            cnt_q   <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
        end else if (accept_c) begin
            cpol_q  <= cpol_i;
            cpha_q  <= cpha_i;
            lsb_q   <= lsb_i;
            len_q   <= eff_len_c;
            cnt_q   <= '0;
            tx_sr_q <= tx_load_c;
            rx_sr_q <= '0;
        end else begin
            if (shift_c && !present_only_c) begin
                tx_sr_q <= tx_next_c;
            end
            if (sample_c) begin
                rx_sr_q <= lsb_q ? {miso_i, rx_sr_q[DATA_WIDTH-1:1]}
                                 : {rx_sr_q[DATA_WIDTH-2:0], miso_i};
                cnt_q   <= CNT_WIDTH'(cnt_q + CNT_WIDTH'(1));
            end
        end
    end

    // Generator must never pulse both edges in one cycle.
    a_single_edge: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(pos_edge_i && neg_edge_i));

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a simple SCLK generator model.
module tb_spi_shift_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          lsb = 1'b0;
    logic [CW-1:0] len = '0;
    logic [DW-1:0] tx = '0;
    logic          sclk;
    logic          pos;
    logic          neg;
    logic          miso;
    logic          busy;
    logic          st;
    logic          last;
    logic          mosi;
    logic [DW-1:0] rx;
    logic          done;

    logic          miso_sel = 1'b1;
    logic          miso_force = 1'b0;
    int            div = 1;
    int            dcnt;

    int            checks = 0;
    int            errors = 0;
    int            done_tot = 0;
    int            rise_tot = 0;
    int            samp_tot = 0;
    int            last_tot = 0;
    logic [DW-1:0] mosi_word = '0;

    assign miso = miso_sel ? mosi : miso_force;

    spi_shift_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
        .lsb_i(lsb), .len_i(len), .tx_data_i(tx), .sclk_i(sclk), .pos_edge_i(pos),
        .neg_edge_i(neg), .miso_i(miso), .busy_o(busy), .st_o(st), .last_o(last),
        .mosi_o(mosi), .rx_data_o(rx), .done_o(done)
    );

    always #5 clk = ~clk;

    // SCLK generator model: toggles every div+1 cycles while busy, parks at idle on last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk <= cpol;
            pos  <= 1'b0;
            neg  <= 1'b0;
            dcnt <= 0;
        end else begin
            pos <= 1'b0;
            neg <= 1'b0;
            if (busy && !(last && (sclk == cpol))) begin
                if (dcnt >= div) begin
                    dcnt <= 0;
                    sclk <= ~sclk;
                    if (sclk) neg <= 1'b1;
                    else      pos <= 1'b1;
                end else begin
                    dcnt <= dcnt + 1;
                end
            end else begin
                dcnt <= 0;
                if (!busy) sclk <= cpol;
            end
        end
    end

    // Event monitors
    always @(negedge clk) begin
        if (done) done_tot++;
        if (busy && pos) rise_tot++;
        if (busy && last) last_tot++;
        if (busy && !last && ((cpol ^ cpha) ? neg : pos)) begin
            samp_tot++;
            mosi_word = {mosi_word[DW-2:0], mosi};
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic p, input logic h, input logic l,
                          input logic [CW-1:0] n, input logic [DW-1:0] w);
        @(negedge clk);
        cpol  = p;
        cpha  = h;
        lsb   = l;
        len   = n;
        tx    = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int            d0;
        int            r0;
        int            s0;
        int            l0;
        logic [DW-1:0] mw;

        repeat (3) @(negedge clk);
        check("reset_outs", {26'd0, busy, st, last, mosi, done, 1'b0} | rx, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: mode 0, MSB first, L=8, loopback
        d0 = done_tot; r0 = rise_tot;
        launch(1'b0, 1'b0, 1'b0, 6'd8, 32'h0000_00A5);
        wait_done("t1_done_seen");
        check("t1_rx", rx, 32'h0000_00A5);
        check("t1_mosi_bits", mosi_word & 32'hFF, 32'h0000_00A5);
        check("t1_done_cnt", 32'(done_tot - d0), 32'd1);
        check("t1_rises", 32'(rise_tot - r0), 32'd8);

        // 2: mode 3, LSB first, L=8, miso tied high
        miso_sel = 1'b0; miso_force = 1'b1;
        d0 = done_tot; l0 = last_tot;
        launch(1'b1, 1'b1, 1'b1, 6'd8, 32'h0000_003C);
        wait_done("t2_done_seen");
        mw = mosi_word;
        check("t2_first_mosi", 32'(mw[7]), 32'd0);
        check("t2_mosi_bits", mw & 32'hFF, 32'h0000_003C);
        check("t2_rx", rx, 32'h0000_00FF);
        check("t2_sclk_idle", 32'(sclk), 32'd1);
        check("t2_last_seen", 32'((last_tot - l0) > 0), 32'd1);
        check("t2_done_cnt", 32'(done_tot - d0), 32'd1);

        // 3: L=0 means 32, mode 1, fastest generator, loopback
        miso_sel = 1'b1; div = 0;
        s0 = samp_tot;
        launch(1'b0, 1'b1, 1'b0, 6'd0, 32'hDEAD_BEEF);
        wait_done("t3_done_seen");
        check("t3_rx", rx, 32'hDEAD_BEEF);
        check("t3_samples", 32'(samp_tot - s0), 32'd32);
        div = 1;

        // 4: L=1, mode 0, miso low
        miso_sel = 1'b0; miso_force = 1'b0;
        d0 = done_tot; r0 = rise_tot;
        launch(1'b0, 1'b0, 1'b0, 6'd1, 32'h0000_0001);
        wait_done("t4_done_seen");
        check("t4_rx", rx, 32'h0000_0000);
        check("t4_rises", 32'(rise_tot - r0), 32'd1);
        check("t4_done_cnt", 32'(done_tot - d0), 32'd1);

        // 4b: len 40 clamps to 32
        miso_sel = 1'b1;
        s0 = samp_tot;
        launch(1'b0, 1'b0, 1'b0, 6'd40, 32'h1234_5678);
        wait_done("t4b_done_seen");
        check("t4b_rx", rx, 32'h1234_5678);
        check("t4b_samples", 32'(samp_tot - s0), 32'd32);

        // 5: reset after 3 bits of a 16-bit transfer
        d0 = done_tot; s0 = samp_tot;
        launch(1'b0, 1'b0, 1'b0, 6'd16, 32'h0000_FFFF);
        for (int i = 0; i < 500 && (samp_tot - s0) < 3; i++) @(negedge clk);
        check("t5_pre_busy_mosi", {30'd0, busy, mosi}, 32'd3);
        rst = 1'b1;
        #1;
        check("t5_abort_outs", {28'd0, busy, last, st, mosi}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_done", 32'(done_tot - d0), 32'd0);
        launch(1'b0, 1'b0, 1'b0, 6'd8, 32'h0000_005A);
        wait_done("t5_restart_done");
        check("t5_restart_rx", rx, 32'h0000_005A);

        // 6: start pulsed mid-transfer is dropped
        d0 = done_tot; s0 = samp_tot;
        launch(1'b0, 1'b0, 1'b0, 6'd16, 32'h0000_BEEF);
        for (int i = 0; i < 500 && (samp_tot - s0) < 5; i++) @(negedge clk);
        tx = 32'h0000_1234; len = 6'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6_done_seen");
        check("t6_rx", rx, 32'h0000_BEEF);
        check("t6_samples", 32'(samp_tot - s0), 32'd16);
        repeat (10) @(negedge clk);
        check("t6_done_cnt", 32'(done_tot - d0), 32'd1);
        check("t6_idle_after", {30'd0, busy, st}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
